// File: rtl/vga_timing_engine.sv
// VGA timing generator and pixel output stage: pixel-clock enable, h/v counters,
// sync/blanking delayed to match the pixel generator latency, and registered RGB.
module vga_timing_engine #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIPE_LAT = 2,
  parameter int RGB_W    = 12,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RGB_W-1:0] rgb_in,
  output logic             pix_tick,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             line_start,
  output logic             frame_start,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [RGB_W-1:0] rgb_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic             SYNC_OFF = ~SYNC_POL;

  typedef struct packed {
    logic hs;
    logic vs;
    logic von;
  } timing_t;

  localparam timing_t IDLE = '{hs: SYNC_OFF, vs: SYNC_OFF, von: 1'b0};

  logic [1:0]       rst_sync;
  logic             run;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;
  timing_t          raw;
  timing_t          dly [PIPE_LAT+1];
  timing_t          tail_in;

  // Release is synchronised; assertion stays asynchronous so outputs clear at once.
  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run = rst_sync[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   div_cnt <= '0;
    else if (run) div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
  end

  assign tick     = run && (div_cnt == DIV_LAST);
  assign pix_tick = tick;
  assign h_wrap   = (h_cnt == H_LAST);
  assign v_wrap   = (v_cnt == V_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= tick && h_wrap;
      frame_start <= tick && h_wrap && v_wrap;
      if (tick) begin
        h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
        if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      end
    end
  end

  assign pix_x = h_cnt;
  assign pix_y = v_cnt;

  // NOTE: raw gets a full default first so no path through this block infers a latch.
  always_comb begin
    raw = IDLE;
    if (h_cnt >= HS_FIRST && h_cnt <= HS_LAST) raw.hs = SYNC_POL;
    if (v_cnt >= VS_FIRST && v_cnt <= VS_LAST) raw.vs = SYNC_POL;
    raw.von = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  end

  // Value entering the last stage; rgb_out loads alongside it to stay aligned.
  generate
    if (PIPE_LAT == 0) begin : g_no_lat
      assign tail_in = raw;
    end else begin : g_lat
      assign tail_in = dly[PIPE_LAT-1];
    end
  endgenerate

  // NOTE: the delay line is reset explicitly so no stale sync pulse escapes after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= PIPE_LAT; i++) dly[i] <= IDLE;
      rgb_out <= '0;
    end else if (tick) begin
      dly[0] <= raw;
      for (int i = 1; i <= PIPE_LAT; i++) dly[i] <= dly[i-1];
      rgb_out <= tail_in.von ? rgb_in : '0;
    end
  end

  assign hsync    = dly[PIPE_LAT].hs;
  assign vsync    = dly[PIPE_LAT].vs;
  assign video_on = dly[PIPE_LAT].von;

endmodule

// File: tb/tb_vga_timing_engine.sv
// Directed bench for vga_timing_engine: default VGA timing, a tiny CLK_DIV=1 mode
// driven from a vector table, and an active-high-sync instance hit by a mid-frame reset.
module tb_vga_timing_engine;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default geometry, PIPE_LAT=2
  logic [11:0] d_rgb;
  logic        d_tick, d_ls, d_fs, d_hs, d_vs, d_von;
  logic [9:0]  d_x, d_y;
  logic [11:0] d_rgbo;

  vga_timing_engine u_def (
    .clk(clk), .reset(reset), .rgb_in(d_rgb), .pix_tick(d_tick), .pix_x(d_x), .pix_y(d_y),
    .line_start(d_ls), .frame_start(d_fs), .hsync(d_hs), .vsync(d_vs), .video_on(d_von),
    .rgb_out(d_rgbo)
  );

  // 12x7 geometry, CLK_DIV=1, PIPE_LAT=0
  logic [11:0] s_rgb;
  logic        s_tick, s_ls, s_fs, s_hs, s_vs, s_von;
  logic [9:0]  s_x, s_y;
  logic [11:0] s_rgbo;

  vga_timing_engine #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .PIPE_LAT(0)
  ) u_small (
    .clk(clk), .reset(reset), .rgb_in(s_rgb), .pix_tick(s_tick), .pix_x(s_x), .pix_y(s_y),
    .line_start(s_ls), .frame_start(s_fs), .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
    .rgb_out(s_rgbo)
  );

  // 12x7 geometry, CLK_DIV=2, PIPE_LAT=2, active-high sync
  logic [11:0] p_rgb;
  logic        p_tick, p_ls, p_fs, p_hs, p_vs, p_von;
  logic [9:0]  p_x, p_y;
  logic [11:0] p_rgbo;

  vga_timing_engine #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1), .PIPE_LAT(2)
  ) u_pol (
    .clk(clk), .reset(reset), .rgb_in(p_rgb), .pix_tick(p_tick), .pix_x(p_x), .pix_y(p_y),
    .line_start(p_ls), .frame_start(p_fs), .hsync(p_hs), .vsync(p_vs), .video_on(p_von),
    .rgb_out(p_rgbo)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else             n_pass++;
  endtask

  // Sample index k counts clocks from the u_small frame_start used for alignment.
  typedef struct {
    int k;
    int rgb;
    int x, y;
    int ls, fs, hs, vs, von;
    int rgbo;
  } vec_t;

  vec_t vecs [17];
  int   k;

  // Packs every compared u_small output; pix_tick is expected high throughout.
  function automatic logic [38:0] pack_small(input logic [9:0] x, input logic [9:0] y,
                                             input logic ls, input logic fs, input logic hs,
                                             input logic vs, input logic von, input logic tk,
                                             input logic [11:0] rgbo);
    return {x, y, ls, fs, hs, vs, von, tk, 1'b0, rgbo};
  endfunction

  initial begin
    int n;
    int hs_fx, hs_fy, hs_w, hs_st;
    int vs_fx, vs_fy, vs_w, vs_st;

    //           k   rgb     x   y  ls fs hs vs von rgbo
    vecs[0]  = '{ 0, 'hABC,  0,  0, 1, 1, 1, 1, 0, 'h000};
    vecs[1]  = '{ 1, 'h123,  1,  0, 0, 0, 1, 1, 1, 'h123};
    vecs[2]  = '{ 8, 'h456,  8,  0, 0, 0, 1, 1, 1, 'h456};
    vecs[3]  = '{ 9, 'h789,  9,  0, 0, 0, 1, 1, 0, 'h000};
    vecs[4]  = '{10, 'hABC, 10,  0, 0, 0, 0, 1, 0, 'h000};
    vecs[5]  = '{11, 'hABC, 11,  0, 0, 0, 0, 1, 0, 'h000};
    vecs[6]  = '{12, 'hABC,  0,  1, 1, 0, 1, 1, 0, 'h000};
    vecs[7]  = '{13, 'hDEF,  1,  1, 0, 0, 1, 1, 1, 'hDEF};
    vecs[8]  = '{48, 'hDEF,  0,  4, 1, 0, 1, 1, 0, 'h000};
    vecs[9]  = '{49, 'hFFF,  1,  4, 0, 0, 1, 1, 0, 'h000};
    vecs[10] = '{60, 'hFFF,  0,  5, 1, 0, 1, 1, 0, 'h000};
    vecs[11] = '{61, 'hFFF,  1,  5, 0, 0, 1, 0, 0, 'h000};
    vecs[12] = '{70, 'hFFF, 10,  5, 0, 0, 0, 0, 0, 'h000};
    vecs[13] = '{72, 'hFFF,  0,  6, 1, 0, 1, 0, 0, 'h000};
    vecs[14] = '{73, 'hFFF,  1,  6, 0, 0, 1, 1, 0, 'h000};
    vecs[15] = '{84, 'hABC,  0,  0, 1, 1, 1, 1, 0, 'h000};
    vecs[16] = '{85, 'h321,  1,  0, 0, 0, 1, 1, 1, 'h321};

    reset = 1'b0;
    d_rgb = 12'hABC;
    s_rgb = 12'hABC;
    p_rgb = 12'h5A5;
    repeat (3) @(negedge clk);

    check("reset_def", {d_x, d_y, d_tick, d_ls, d_fs, d_hs, d_vs, d_von, d_rgbo},
          {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000});
    check("reset_small", {s_x, s_y, s_tick, s_ls, s_fs, s_hs, s_vs, s_von, s_rgbo},
          {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000});
    check("reset_pol", {p_x, p_y, p_tick, p_hs, p_vs, p_von, p_rgbo},
          {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000});

    // Release: the synchroniser lets counting begin from the second clock edge.
    reset = 1'b1;
    @(negedge clk);
    check("release_edge1_tick", {s_tick, s_x}, {1'b0, 10'd0});
    @(negedge clk);
    check("release_edge2_tick", {s_tick, s_x}, {1'b1, 10'd0});
    @(negedge clk);
    check("release_edge3_count", {s_tick, s_x}, {1'b1, 10'd1});

    // Line 0 of the default instance: video_on appears 3 ticks after pix_x=0.
    for (n = 0; n < 100 && !d_von; n++) @(negedge clk);
    check("def_video_on_rise", {d_von, d_x, d_y, d_rgbo}, {1'b1, 10'd3, 10'd0, 12'hABC});

    // Table-driven walk through a full small frame plus the wrap.
    for (n = 0; n < 300 && !s_fs; n++) @(negedge clk);
    k = 0;
    foreach (vecs[i]) begin
      while (k < vecs[i].k - 1) begin
        @(negedge clk);
        k++;
      end
      if (k == vecs[i].k - 1) begin
        s_rgb = 12'(vecs[i].rgb);
        @(negedge clk);
        k++;
      end
      check($sformatf("small_k%0d", vecs[i].k),
            pack_small(s_x, s_y, s_ls, s_fs, s_hs, s_vs, s_von, s_tick, s_rgbo),
            pack_small(10'(vecs[i].x), 10'(vecs[i].y), 1'(vecs[i].ls), 1'(vecs[i].fs),
                       1'(vecs[i].hs), 1'(vecs[i].vs), 1'(vecs[i].von), 1'b1,
                       12'(vecs[i].rgbo)));
    end

    // Default instance: blanking and sync placement within line 0.
    for (n = 0; n < 4000 && d_von; n++) @(negedge clk);
    check("def_video_on_fall", {d_von, d_x, d_rgbo}, {1'b0, 10'd643, 12'h000});

    for (n = 0; n < 400 && d_hs; n++) @(negedge clk);
    check("def_hsync_fall", {d_hs, d_x, d_y}, {1'b0, 10'd659, 10'd0});

    for (n = 0; n < 1000 && !d_hs; n++) @(negedge clk);
    check("def_hsync_low_clks", 64'(n), 64'd384);

    for (n = 0; n < 4000 && !d_ls; n++) @(negedge clk);
    check("def_line_start_pos", {d_ls, d_x, d_y}, {1'b1, 10'd0, 10'd1});

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_ls && n < 4000);
    check("def_line_period_clks", 64'(n), 64'd3200);

    for (n = 0; n < 10 && !d_tick; n++) @(negedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_tick && n < 10);
    check("def_tick_period_clks", 64'(n), 64'd4);

    // Mid-frame reset on u_pol while its vsync window is live.
    for (n = 0; n < 400 && !(p_x == 10'd9 && p_y == 10'd5); n++) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_pol", {p_x, p_y, p_tick, p_ls, p_fs, p_hs, p_vs, p_von, p_rgbo},
          {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000});
    check("midreset_def", {d_x, d_y, d_tick, d_ls, d_fs, d_hs, d_vs, d_von, d_rgbo},
          {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000});
    repeat (5) @(negedge clk);
    reset = 1'b1;

    // After release: the first sync pulses must be full-width and correctly placed.
    hs_fx = -1; hs_fy = -1; hs_w = 0; hs_st = 0;
    vs_fx = -1; vs_fy = -1; vs_w = 0; vs_st = 0;
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      if (p_fs) break;
      if (hs_st == 0 && p_hs) begin hs_fx = int'(p_x); hs_fy = int'(p_y); hs_st = 1; end
      if (hs_st == 1) begin
        if (p_hs) hs_w++;
        else      hs_st = 2;
      end
      if (vs_st == 0 && p_vs) begin vs_fx = int'(p_x); vs_fy = int'(p_y); vs_st = 1; end
      if (vs_st == 1) begin
        if (p_vs) vs_w++;
        else      vs_st = 2;
      end
    end
    check("pol_first_frame_start", {p_fs, p_x, p_y}, {1'b1, 10'd0, 10'd0});
    check("pol_hsync_first_pos", {32'(hs_fx), 32'(hs_fy)}, {32'd0, 32'd1});
    check("pol_hsync_width_clks", 64'(hs_w), 64'd4);
    check("pol_vsync_first_pos", {32'(vs_fx), 32'(vs_fy)}, {32'd3, 32'd5});
    check("pol_vsync_width_clks", 64'(vs_w), 64'd24);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
